// File: rtl/gpio_led_pkg.sv
// Register map and shared helpers for the memory-mapped GPIO/LED peripheral.
package gpio_led_pkg;

  localparam int unsigned GpioWindowBytes = 64;

  localparam logic [5:0] GPIO_OUT_OFFSET       = 6'h00;
  localparam logic [5:0] GPIO_OUT_SET_OFFSET   = 6'h04;
  localparam logic [5:0] GPIO_OUT_CLR_OFFSET   = 6'h08;
  localparam logic [5:0] GPIO_OUT_TGL_OFFSET   = 6'h0C;
  localparam logic [5:0] GPIO_BLINK_EN_OFFSET  = 6'h10;
  localparam logic [5:0] GPIO_BLINK_DIV_OFFSET = 6'h14;
  localparam logic [5:0] GPIO_IN_OFFSET        = 6'h18;
  localparam logic [5:0] GPIO_EDGE_OFFSET      = 6'h1C;
  localparam logic [5:0] GPIO_IRQ_EN_OFFSET    = 6'h20;

  // Word index within the window, i.e. offset >> 2.
  typedef enum logic [3:0] {
    REG_OUT       = 4'd0,
    REG_OUT_SET   = 4'd1,
    REG_OUT_CLR   = 4'd2,
    REG_OUT_TGL   = 4'd3,
    REG_BLINK_EN  = 4'd4,
    REG_BLINK_DIV = 4'd5,
    REG_IN        = 4'd6,
    REG_EDGE      = 4'd7,
    REG_IRQ_EN    = 4'd8
  } gpio_reg_e;

  function automatic logic [31:0] be_to_mask(input logic [3:0] be);
    return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
  endfunction

endpackage

// File: rtl/gpio_blink_gen.sv
// Blink phase generator: phase toggles every div_i cycles; div_i=0 or restart_i holds it at 0.
module gpio_blink_gen #(
  parameter int unsigned DivWidth = 24
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic [DivWidth-1:0] div_i,
  input  logic                restart_i,
  output logic                phase_o
);

  logic [DivWidth-1:0] cnt_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q   <= '0;
      phase_o <= 1'b0;
    end else if (restart_i || (div_i == '0)) begin
      cnt_q   <= '0;
      phase_o <= 1'b0;
    end else if (cnt_q == div_i - DivWidth'(1)) begin
      cnt_q   <= '0;
      phase_o <= ~phase_o;
    end else begin
      cnt_q <= cnt_q + DivWidth'(1);
    end
  end

endmodule

// File: rtl/gpio_led_periph.sv
// GPIO/LED slave on the Ibex data bus: set/clr/toggle outputs, hardware blink,
// synchronised inputs with latched rising edges and a level interrupt.
module gpio_led_periph
  import gpio_led_pkg::*;
#(
  parameter int unsigned NumOut     = 8,
  parameter int unsigned NumIn      = 8,
  parameter int unsigned DivWidth   = 24,
  parameter int unsigned SyncStages = 2
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              req_i,
  input  logic              we_i,
  input  logic [3:0]        be_i,
  input  logic [31:0]       addr_i,
  input  logic [31:0]       wdata_i,
  output logic              gnt_o,
  output logic              rvalid_o,
  output logic [31:0]       rdata_o,
  output logic              err_o,
  input  logic [NumIn-1:0]  gpio_i,
  output logic [NumOut-1:0] gpio_o,
  output logic              irq_o
);

  logic [3:0]          idx;
  logic                acc_err, wr;
  logic [31:0]         bmask, wbits, rd_val;
  logic [NumOut-1:0]   out_q, blink_en_q, out_wm, out_wb;
  logic [DivWidth-1:0] div_q, div_wm, div_wb;
  logic [NumIn-1:0]    edge_q, irq_en_q, in_wm, in_wb, edge_clr;
  logic [NumIn-1:0]    in_sync, in_sync_q, edge_det;
  logic [SyncStages-1:0][NumIn-1:0] sync_q;
  logic                phase;
  logic                unused_bits;

  assign idx     = addr_i[5:2];
  assign gnt_o   = req_i;
  assign acc_err = (addr_i[1:0] != 2'b00) || (idx > REG_IRQ_EN) || (we_i && (idx == REG_IN));
  assign wr      = req_i && we_i && !acc_err;

  assign bmask  = be_to_mask(be_i);
  assign wbits  = wdata_i & bmask;
  assign out_wm = bmask[NumOut-1:0];
  assign out_wb = wbits[NumOut-1:0];
  assign div_wm = bmask[DivWidth-1:0];
  assign div_wb = wbits[DivWidth-1:0];
  assign in_wm  = bmask[NumIn-1:0];
  assign in_wb  = wbits[NumIn-1:0];
  assign unused_bits = ^{addr_i[31:6], bmask, wbits};

  // Shift register synchroniser; the newest sample enters at index 0.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) sync_q <= '0;
    else         sync_q <= {sync_q[SyncStages-2:0], gpio_i};
  end

  assign in_sync  = sync_q[SyncStages-1];
  assign edge_det = in_sync & ~in_sync_q;
  // A new edge beats a simultaneous write-1-clear on the same bit.
  assign edge_clr = (wr && (idx == REG_EDGE)) ? in_wb : '0;

  gpio_blink_gen #(.DivWidth(DivWidth)) u_blink (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .div_i     (div_q),
    .restart_i (wr && (idx == REG_BLINK_DIV) && (|be_i)),
    .phase_o   (phase)
  );

  always_comb begin
    rd_val = '0;
    case (idx)
      REG_OUT:       rd_val[NumOut-1:0]   = out_q;
      REG_BLINK_EN:  rd_val[NumOut-1:0]   = blink_en_q;
      REG_BLINK_DIV: rd_val[DivWidth-1:0] = div_q;
      REG_IN:        rd_val[NumIn-1:0]    = in_sync;
      REG_EDGE:      rd_val[NumIn-1:0]    = edge_q;
      REG_IRQ_EN:    rd_val[NumIn-1:0]    = irq_en_q;
      default:       rd_val = '0;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      out_q      <= '0;
      blink_en_q <= '0;
      div_q      <= '0;
      edge_q     <= '0;
      irq_en_q   <= '0;
      in_sync_q  <= '0;
      gpio_o     <= '0;
      irq_o      <= 1'b0;
      rvalid_o   <= 1'b0;
      rdata_o    <= '0;
      err_o      <= 1'b0;
    end else begin
      if (wr) begin
        case (idx)
          REG_OUT:       out_q      <= (out_q & ~out_wm) | out_wb;
          REG_OUT_SET:   out_q      <= out_q | out_wb;
          REG_OUT_CLR:   out_q      <= out_q & ~out_wb;
          REG_OUT_TGL:   out_q      <= out_q ^ out_wb;
          REG_BLINK_EN:  blink_en_q <= (blink_en_q & ~out_wm) | out_wb;
          REG_BLINK_DIV: div_q      <= (div_q & ~div_wm) | div_wb;
          REG_IRQ_EN:    irq_en_q   <= (irq_en_q & ~in_wm) | in_wb;
          default:       ;
        endcase
      end
      in_sync_q <= in_sync;
      edge_q    <= (edge_q & ~edge_clr) | edge_det;
      irq_o     <= |(edge_q & irq_en_q);
      gpio_o    <= out_q ^ (blink_en_q & {NumOut{phase}});
      rvalid_o  <= req_i;
      err_o     <= req_i && acc_err;
      rdata_o   <= (req_i && !we_i && !acc_err) ? rd_val : '0;
    end
  end

endmodule
